// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for the seven-segment scan driver: CPU value/control in,
// shared segment bus and digit enables out.
interface seven_seg_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  lz_en;
    logic                  blank;
    logic [6:0]            seg_out;
    logic [DIGITS-1:0]     dig_en;
    logic                  frame_start;
    logic                  pending;

    modport master (
        output load, value, lz_en, blank,
        input  seg_out, dig_en, frame_start, pending
    );

    modport slave (
        input  load, value, lz_en, blank,
        output seg_out, dig_en, frame_start, pending
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, leading-zero suppression, global blank and anti-ghost guard.
module seven_seg_scan_driver #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic            clk,
    input  logic            reset,
    seven_seg_scan_if.slave bus
);
    localparam int unsigned DW    = 4 * DIGITS;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]  div_q,     div_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [DW-1:0]     shadow_q,  shadow_d;
    logic [DW-1:0]     disp_q,    disp_d;
    logic              pending_q, pending_d;
    logic [6:0]        seg_q,     seg_d;
    logic [DIGITS-1:0] dig_q,     dig_d;
    logic              frame_q,   frame_d;

    logic              terminal_c;
    logic              wrap_c;
    logic [DIGITS-1:0] hi_zero_c;
    logic [3:0]        nib_c;
    logic              sup_c;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign terminal_c = (div_q == DIV_W'(CLK_DIV - 1));
    assign wrap_c     = terminal_c && (idx_q == IDX_W'(DIGITS - 1));

    // Scan counters and frame-synchronous shadow -> display transfer
    always_comb begin
        div_d     = div_q + DIV_W'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        frame_d   = wrap_c;

        if (terminal_c) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        if (bus.load) begin
            shadow_d = bus.value;
            if (wrap_c) begin
                disp_d    = bus.value;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (wrap_c && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Current digit nibble and whether it falls in the leading-zero run
    always_comb begin
        logic run_zero;
        run_zero  = 1'b1;
        hi_zero_c = '0;
        nib_c     = 4'h0;
        sup_c     = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            run_zero     = run_zero & (disp_q[4*i +: 4] == 4'h0);
            hi_zero_c[i] = run_zero;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_c = disp_q[4*i +: 4];
                sup_c = bus.lz_en && (i != 0) && hi_zero_c[i];
            end
        end
    end

    // Segment/enable drive; the terminal cycle is always dark to stop ghosting
    always_comb begin
        seg_d = hex_to_seg(nib_c);
        dig_d = ~(DIGITS'(1) << idx_q);
        if (terminal_c || bus.blank || sup_c) begin
            seg_d = 7'b1111111;
            dig_d = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'b1111111;
            dig_q     <= '1;
            frame_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.dig_en      = dig_q;
    assign bus.frame_start = frame_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 4-digit and a 1-digit instance checked
// every cycle against a time-based reference model plus directed spot checks.
module tb_seven_seg_scan_driver;
    localparam int unsigned A_DIGITS = 4;
    localparam int unsigned A_DIV    = 4;
    localparam int unsigned B_DIGITS = 1;
    localparam int unsigned B_DIV    = 2;

    logic clk = 1'b0;
    logic rst;

    seven_seg_scan_if #(.DIGITS(A_DIGITS)) ifa ();
    seven_seg_scan_if #(.DIGITS(B_DIGITS)) ifb ();

    seven_seg_scan_driver #(.DIGITS(A_DIGITS), .CLK_DIV(A_DIV)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa.slave)
    );

    seven_seg_scan_driver #(.DIGITS(B_DIGITS), .CLK_DIV(B_DIV)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: cycles since reset, shadow, shown value, pending
    int          mt  [2];
    logic [31:0] msh [2];
    logic [31:0] mdp [2];
    logic        mpd [2];
    logic [6:0]  seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scan position follows from elapsed cycles: div = t mod CLK_DIV, idx = (t / CLK_DIV) mod DIGITS
    task automatic model_step(input int k, input logic r, input logic ld, input logic [31:0] val,
                              input logic lz, input logic blk,
                              output logic [6:0] es, output logic [7:0] ed,
                              output logic ef, output logic ep);
        int d, cd, dv, idx, dmask;
        logic [31:0] above;
        logic term, wrap;
        d     = (k == 0) ? int'(A_DIGITS) : int'(B_DIGITS);
        cd    = (k == 0) ? int'(A_DIV)    : int'(B_DIV);
        dmask = (1 << d) - 1;
        if (r) begin
            mt[k]  = 0;
            msh[k] = '0;
            mdp[k] = '0;
            mpd[k] = 1'b0;
            es = 7'h7F; ed = 8'(dmask); ef = 1'b0; ep = 1'b0;
            return;
        end
        dv    = mt[k] % cd;
        idx   = (mt[k] / cd) % d;
        term  = (dv == cd - 1);
        wrap  = term && (idx == d - 1);
        above = mdp[k] >> (4 * idx);
        if (term || blk || (lz && idx > 0 && above == 0)) begin
            es = 7'h7F;
            ed = 8'(dmask);
        end else begin
            es = seg_tab[above[3:0]];
            ed = 8'(dmask & ~(1 << idx));
        end
        ef = wrap;
        if (ld) begin
            msh[k] = val;
            if (wrap) begin
                mdp[k] = val;
                mpd[k] = 1'b0;
            end else begin
                mpd[k] = 1'b1;
            end
        end else if (wrap && mpd[k]) begin
            mdp[k] = msh[k];
            mpd[k] = 1'b0;
        end
        ep = mpd[k];
        mt[k]++;
    endtask

    task automatic tick();
        logic [6:0] es0, es1;
        logic [7:0] ed0, ed1;
        logic ef0, ef1, ep0, ep1;
        model_step(0, rst, ifa.load, 32'(ifa.value), ifa.lz_en, ifa.blank, es0, ed0, ef0, ep0);
        model_step(1, rst, ifb.load, 32'(ifb.value), ifb.lz_en, ifb.blank, es1, ed1, ef1, ep1);
        @(posedge clk);
        #1;
        chk("a_seg",  32'(ifa.seg_out),     32'(es0));
        chk("a_dig",  32'(ifa.dig_en),      32'(ed0[3:0]));
        chk("a_fs",   32'(ifa.frame_start), 32'(ef0));
        chk("a_pend", 32'(ifa.pending),     32'(ep0));
        chk("b_seg",  32'(ifb.seg_out),     32'(es1));
        chk("b_dig",  32'(ifb.dig_en),      32'(ed1[0:0]));
        chk("b_fs",   32'(ifb.frame_start), 32'(ef1));
        chk("b_pend", 32'(ifb.pending),     32'(ep1));
    endtask

    task automatic wait_frame(input int k);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            tick();
            seen = (k == 0) ? ifa.frame_start : ifb.frame_start;
        end
        chk((k == 0) ? "a_frame_seen" : "b_frame_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        rst = 1'b1;
        ifa.load = 1'b0; ifa.value = '0; ifa.lz_en = 1'b0; ifa.blank = 1'b0;
        ifb.load = 1'b0; ifb.value = '0; ifb.lz_en = 1'b0; ifb.blank = 1'b0;
        #1;

        // Reset hold and first digit after release
        repeat (3) tick();
        chk("rst_seg",  32'(ifa.seg_out), 32'h7F);
        chk("rst_dig",  32'(ifa.dig_en),  32'hF);
        chk("rst_pend", 32'(ifa.pending), 32'd0);
        rst = 1'b0;
        tick();
        chk("first_seg", 32'(ifa.seg_out), 32'b1000000);
        chk("first_dig", 32'(ifa.dig_en),  32'b1110);

        // Scan of 12AF
        ifa.value = 16'h12AF; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        chk("load_pend", 32'(ifa.pending), 32'd1);
        wait_frame(0);
        tick();
        chk("scan_d0_seg", 32'(ifa.seg_out), 32'b0001110);
        chk("scan_d0_dig", 32'(ifa.dig_en),  32'b1110);
        repeat (3) tick();
        tick();
        chk("scan_d1_seg", 32'(ifa.seg_out), 32'b0001000);
        chk("scan_d1_dig", 32'(ifa.dig_en),  32'b1101);
        repeat (3) tick();
        tick();
        chk("scan_d2_seg", 32'(ifa.seg_out), 32'b0100100);
        chk("scan_d2_dig", 32'(ifa.dig_en),  32'b1011);
        repeat (3) tick();
        tick();
        chk("scan_d3_seg", 32'(ifa.seg_out), 32'b1111001);
        chk("scan_d3_dig", 32'(ifa.dig_en),  32'b0111);
        repeat (3) tick();
        chk("fs_period", 32'(ifa.frame_start), 32'd1);

        // Mid-frame load waits for the wrap
        repeat (5) tick();
        ifa.value = 16'h1111; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        chk("mid_pend", 32'(ifa.pending), 32'd1);
        wait_frame(0);
        chk("wrap_pend", 32'(ifa.pending), 32'd0);
        tick();
        chk("ones_seg", 32'(ifa.seg_out), 32'b1111001);

        // Load exactly on the wrap cycle
        for (int n = 0; n < 32 && (mt[0] % 16) != 15; n++) tick();
        ifa.value = 16'h2222; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        chk("onwrap_pend", 32'(ifa.pending),     32'd0);
        chk("onwrap_fs",   32'(ifa.frame_start), 32'd1);
        tick();
        chk("twos_seg", 32'(ifa.seg_out), 32'b0100100);
        chk("twos_dig", 32'(ifa.dig_en),  32'b1110);

        // Leading-zero suppression
        ifa.lz_en = 1'b1;
        ifa.value = 16'h0030; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        wait_frame(0);
        tick();
        chk("lz_d0_seg", 32'(ifa.seg_out), 32'b1000000);
        repeat (3) tick();
        tick();
        chk("lz_d1_seg", 32'(ifa.seg_out), 32'b0110000);
        chk("lz_d1_dig", 32'(ifa.dig_en),  32'b1101);
        repeat (3) tick();
        tick();
        chk("lz_d2_dig", 32'(ifa.dig_en), 32'b1111);
        ifa.value = 16'h0000; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        wait_frame(0);
        tick();
        chk("lz0_d0_seg", 32'(ifa.seg_out), 32'b1000000);
        chk("lz0_d0_dig", 32'(ifa.dig_en),  32'b1110);
        repeat (3) tick();
        tick();
        chk("lz0_d1_dig", 32'(ifa.dig_en), 32'b1111);
        repeat (12) tick();

        // Blank mid-digit; frames keep running
        ifa.lz_en = 1'b0;
        repeat (2) tick();
        ifa.blank = 1'b1;
        tick();
        chk("blank_dig", 32'(ifa.dig_en),  32'b1111);
        chk("blank_seg", 32'(ifa.seg_out), 32'h7F);
        wait_frame(0);
        ifa.blank = 1'b0;

        // Randomized traffic on both instances
        for (int n = 0; n < 400; n++) begin
            ifa.load  = ($urandom_range(0, 5) == 0);
            ifa.value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ifa.lz_en = ~ifa.lz_en;
            if ($urandom_range(0, 19) == 0) ifa.blank = ~ifa.blank;
            ifb.load  = ($urandom_range(0, 3) == 0);
            ifb.value = 4'($urandom);
            ifb.lz_en = 1'($urandom);
            ifb.blank = ($urandom_range(0, 9) == 0);
            tick();
        end
        ifa.load = 1'b0; ifa.lz_en = 1'b0; ifa.blank = 1'b0;
        ifb.load = 1'b0; ifb.lz_en = 1'b0; ifb.blank = 1'b0;

        // Asynchronous reset between clock edges drops the loaded value
        ifa.value = 16'hBEEF; ifa.load = 1'b1;
        tick();
        ifa.load = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_seg",   32'(ifa.seg_out),     32'h7F);
        chk("arst_dig",   32'(ifa.dig_en),      32'hF);
        chk("arst_pend",  32'(ifa.pending),     32'd0);
        chk("arst_fs",    32'(ifa.frame_start), 32'd0);
        chk("arst_b_dig", 32'(ifb.dig_en),      32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_arst_seg", 32'(ifa.seg_out), 32'b1000000);
        chk("post_arst_dig", 32'(ifa.dig_en),  32'b1110);

        // Single-digit instance
        ifb.value = 4'hC; ifb.load = 1'b1;
        tick();
        ifb.load = 1'b0;
        wait_frame(1);
        tick();
        chk("b1_seg", 32'(ifb.seg_out), 32'b1000110);
        chk("b1_dig", 32'(ifb.dig_en),  32'd0);
        tick();
        chk("b1_guard_seg", 32'(ifb.seg_out),     32'h7F);
        chk("b1_guard_dig", 32'(ifb.dig_en),      32'd1);
        chk("b1_fs",        32'(ifb.frame_start), 32'd1);
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
